fifo_write_arbiter: RTL

//  Round-robin, burst-capable arbiter that shares the async FIFO write port among N requesters.

---
 rtl/fifo_warb_pkg.sv | 38 +++
 rtl/fifo_write_arbiter_rr_pick_onehot.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_warb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// statistics counter width and the cyclic one-hot priority pick.
package fifo_warb_pkg;

    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 8;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_BURST = ST_BURST
    } warb_state_e;

    // One-hot winner: first set bit of req at or after ptr, wrapping at n.
    // Bits of req at or above n are never examined.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int unsigned         ptr,
                                                   input int unsigned         n);
        logic [MAX_REQ-1:0] win;
        logic               found;
        int unsigned        idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (!found && req[idx[2:0]]) begin
                    win[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick_onehot.sv
// Combinational cyclic priority encoder: one-hot of the first request at or
// after the round-robin pointer.
module rr_pick_onehot
    import fifo_warb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick_ext;
    logic               pick_unused;

    // Widen to the package function's fixed width and take back N_REQ bits.
    always_comb begin
        req_ext            = '0;
        req_ext[N_REQ-1:0] = req;
        pick_ext           = rr_pick(req_ext, {{(32-PTR_W){1'b0}}, ptr}, N_REQ);
        onehot             = pick_ext[N_REQ-1:0];
    end

    assign pick_unused = ^pick_ext;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-capable arbiter sharing the FIFO write port among
// N_REQ requesters. A grant lasts until the owner's last word, MAX_BURST
// words, or the owner dropping req; then one idle cycle precedes the next.
// Optional build macro FIFO_WARB_STATS_EN adds per-requester saturating
// accepted-word counters (word_cnt) with a synchronous clear (stats_clr).
// Handshake: a word on req[i] is accepted in the cycle where ack[i]=1
// (req held with grant, FIFO not full); the requester holds req, req_last and
// data stable until then.
module fifo_write_arbiter
    import fifo_warb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                   w_clk,
    input  logic                   w_reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*DW-1:0]    req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       grant,
    input  logic                   fifo_full,
    output logic                   fifo_w_en,
    output logic [DW-1:0]          fifo_w_data,
`ifdef FIFO_WARB_STATS_EN
    input  logic                   stats_clr,
    output logic [N_REQ*CNT_W-1:0] word_cnt,
`endif
    output logic                   dbg_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W  = 8;
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(N_REQ - 1);

    warb_state_e       state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]  own_q, own_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [PTR_W-1:0]  pick_idx;
    logic              in_burst;
    logic              own_req;
    logic              own_last;
    logic              xfer;
    logic              burst_end;

    rr_pick_onehot #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot)
    );

    // Binary index of the picked requester, stored so the burst mux needs no decode.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) pick_idx = PTR_W'(i);
        end
    end

    // Owner datapath: write port driven straight from the registered owner.
    always_comb begin
        in_burst    = (state_q == S_BURST);
        own_req     = req[own_q];
        own_last    = req_last[own_q];
        xfer        = in_burst & own_req & ~fifo_full;
        ack         = grant_q & {N_REQ{xfer}};
        fifo_w_en   = xfer;
        fifo_w_data = in_burst ? req_data[own_q*DW +: DW] : '0;
        burst_end   = in_burst & (~own_req | (xfer & (own_last | (burst_cnt_q == BURST_LAST))));
    end

    // Next-state logic: pick in IDLE, count and terminate bursts in BURST.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        own_d       = own_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d     = S_BURST;
                    grant_d     = pick_onehot;
                    own_d       = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (burst_end) begin
                    state_d     = S_IDLE;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (own_q == PTR_MAX) ? '0 : own_q + 1'b1;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset drops the grant immediately, abandoning any burst.
    always_ff @(posedge w_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            own_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            own_q       <= own_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign dbg_state = state_q;

`ifdef FIFO_WARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // Per-requester accepted-word counters; clear beats a same-cycle ack.
    always_ff @(posedge w_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= '0;
                end else if (ack[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        word_cnt = '0;
        for (int i = 0; i < N_REQ; i++) word_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule
